icon_loader: RTL and testbench

ICON_LOADER -- requirements
Module: icon_loader

---
 rtl/icon_loader.sv | 116 +++++++++++
 tb/tb_icon_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/icon_loader.sv
// Streams 64 packed bitmap bytes into a 16x16 2-bit icon slot, one pixel per write.
// Optional ICON_LOADER_CHECKSUM_EN adds a trailer byte compared against the 8-bit byte sum.
module icon_loader (
  input  logic        vga_clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  IconSel,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        we,
  output logic [11:0] waddr,
  output logic [1:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef ICON_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_LAST  = S_CHECK;
`else
  localparam logic [2:0] S_LAST  = S_DONE;
`endif

  logic [2:0] r_state;
  logic [3:0] r_slot;
  logic [7:0] r_cnt;
  logic [7:0] r_byte;
  logic [1:0] r_phase;
`ifdef ICON_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
`endif

  logic w_accept;

`ifdef ICON_LOADER_CHECKSUM_EN
  assign din_ready = (r_state == S_FETCH) || (r_state == S_CHECK);
  assign err       = r_err;
`else
  assign din_ready = (r_state == S_FETCH);
  assign err       = 1'b0;
`endif

  assign w_accept = din_ready && din_valid;
  assign we       = (r_state == S_WRITE);
  assign waddr    = {r_slot, r_cnt};
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

  // Pixel 0 of each byte sits in the low bits.
  always_comb begin
    wdata = r_byte[1:0];
    case (r_phase)
      2'd1:    wdata = r_byte[3:2];
      2'd2:    wdata = r_byte[5:4];
      2'd3:    wdata = r_byte[7:6];
      default: wdata = r_byte[1:0];
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_slot  <= 4'd0;
      r_cnt   <= 8'd0;
      r_byte  <= 8'd0;
      r_phase <= 2'd0;
`ifdef ICON_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_slot  <= IconSel;
          r_cnt   <= 8'd0;
          r_phase <= 2'd0;
`ifdef ICON_LOADER_CHECKSUM_EN
          r_sum   <= 8'd0;
          r_err   <= 1'b0;
`endif
          r_state <= S_FETCH;
        end
        S_FETCH: if (w_accept) begin
          r_byte  <= din;
`ifdef ICON_LOADER_CHECKSUM_EN
          r_sum   <= r_sum + din;
`endif
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_cnt   <= r_cnt + 8'd1;
          r_phase <= r_phase + 2'd1;
          // Counter about to wrap means the 256th pixel is going out now.
          if (r_phase == 2'd3)
            r_state <= (r_cnt == 8'hFF) ? S_LAST : S_FETCH;
        end
`ifdef ICON_LOADER_CHECKSUM_EN
        S_CHECK: if (w_accept) begin
          r_err   <= (din != r_sum);
          r_state <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icon_loader.sv
// Directed bench for icon_loader: write-stream scoreboard, handshake pacing, reset abort, ignored start.
module tb_icon_loader;

`ifdef ICON_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        vga_clock, reset_n, start, din_valid;
  logic [3:0]  IconSel;
  logic [7:0]  din;
  logic        din_ready, we, busy, done, err;
  logic [11:0] waddr;
  logic [1:0]  wdata;

  int n_chk = 0, n_fail = 0;
  int wr_cnt, nacc, done_cnt, busy_cyc, rdy_cyc;
  logic [3:0] exp_slot;
  logic [7:0] bytes [0:64];
  logic [7:0] sum1;

  icon_loader dut (
    .vga_clock(vga_clock), .reset_n(reset_n), .start(start), .IconSel(IconSel),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .we(we),
    .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int n);
    case (mode)
      0:       return 8'hE4;
      1:       return 8'(n * 37 + 5);
      default: return 8'h01;
    endcase
  endfunction

  // Write-stream scoreboard against the bytes the driver handed over.
  always @(negedge vga_clock) if (reset_n) begin
    logic [7:0]  b;
    logic [31:0] ed;
    if (busy) busy_cyc++;
    if (din_ready) rdy_cyc++;
    if (we) begin
      chk("wr_range", 32'(wr_cnt < 256), 1);
      chk("waddr", 32'(waddr), 32'({exp_slot, 8'(wr_cnt)}));
      b  = bytes[(wr_cnt / 4) % 64];
      ed = 32'((b >> (2 * (wr_cnt % 4))) & 8'h3);
      chk("wdata", 32'(wdata), ed);
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_nbytes", nacc, 64 + CK);
      chk("done_nwr", wr_cnt, 256);
      chk("done_busy", 32'(busy), 1);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},   32'(din_ready), 0);
    chk({tag, "_we"},    32'(we), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wdata"}, 32'(wdata), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  task automatic run_load(input logic [3:0] sel, input int mode, input bit rnd,
                          input logic [7:0] trailer, input int abort_wr, input int poke_cyc);
    exp_slot = sel; wr_cnt = 0; nacc = 0; done_cnt = 0; busy_cyc = 0; rdy_cyc = 0;
    @(negedge vga_clock); #1;
    IconSel = sel; start = 1'b1;
    @(negedge vga_clock); #1;
    start = 1'b0; IconSel = ~sel;
    chk("busy_start", 32'(busy), 1);
    chk("err_clr", 32'(err), 0);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      if (abort_wr > 0 && wr_cnt >= abort_wr) begin
        reset_n = 1'b0; din_valid = 1'b0;
        #1 chk_zero("rst_async");
        repeat (3) begin
          @(negedge vga_clock);
          chk("rst_we", 32'(we), 0);
        end
        #1 reset_n = 1'b1;
        repeat (3) begin
          @(negedge vga_clock);
          chk("post_rst_we", 32'(we), 0);
          chk("post_rst_done", 32'(done), 0);
        end
        return;
      end
      if (c == poke_cyc) begin start = 1'b1; IconSel = 4'hF; end
      else start = 1'b0;
      din       = (nacc >= 64) ? trailer : pat(mode, nacc);
      din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (din_valid && din_ready) begin bytes[nacc] = din; nacc++; end
      @(negedge vga_clock); #1;
    end
    if (done_cnt == 0) chk("timeout_done", 0, 1);
    din_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge vga_clock);
    chk("one_done", done_cnt, 1);
    chk("idle_busy", 32'(busy), 0);
    chk("nwrites", wr_cnt, 256);
    if (!rnd) begin
      chk("busy_cyc", busy_cyc, 321 + CK);
      chk("rdy_cyc", rdy_cyc, 64 + CK);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; din_valid = 1'b0; IconSel = 4'h0; din = 8'h00;
    for (int i = 0; i < 65; i++) bytes[i] = 8'h00;
    sum1 = 8'h00;
    for (int i = 0; i < 64; i++) sum1 = sum1 + pat(1, i);
    #12 chk_zero("reset");
    @(negedge vga_clock); reset_n = 1'b1;

    run_load(4'h3, 0, 1'b0, 8'h00, 0, -1);
    chk("err_l1", 32'(err), 0);
    run_load(4'h6, 1, 1'b1, sum1, 0, -1);
    chk("err_rnd", 32'(err), 0);
    run_load(4'h9, 1, 1'b0, sum1, 0, 50);
    run_load(4'h5, 0, 1'b0, 8'h00, 38, -1);
    run_load(4'h0, 1, 1'b0, sum1, 0, -1);

`ifdef ICON_LOADER_CHECKSUM_EN
    run_load(4'h2, 2, 1'b0, 8'h40, 0, -1);
    chk("err_good", 32'(err), 0);
    run_load(4'h2, 2, 1'b0, 8'h41, 0, -1);
    chk("err_bad", 32'(err), 1);
    repeat (5) @(negedge vga_clock);
    chk("err_hold", 32'(err), 1);
    run_load(4'h4, 2, 1'b0, 8'h40, 0, -1);
    chk("err_after", 32'(err), 0);
`else
    chk("err_tied", 32'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
